// File: rtl/common.sv
// Core-wide scalar types shared by the pipeline control blocks.
package common;

  typedef logic [63:0] u64;
  typedef u64          word_t;

endpackage

// File: rtl/pipes.sv
// Pipeline control types: hazard scheduler states and the per-stage stall/flush bundle.
package pipes;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_BUBBLE     = 2'd1,
    HZ_REDIR_WAIT = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
  } hazard_ctl_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter that wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = inc ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage core: load-use bubbles, fetch-deferred redirects,
// memory-busy freezes, and stall/redirect performance counters.
module hazard_ctrl
  import common::*;
  import pipes::*;
#(
  parameter int LOADUSE_BUBBLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             dec_hazard,
  input  logic             dec_jump,
  input  word_t            dec_target,
  input  logic             ibus_busy,
  input  logic             dbus_busy,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             redirect_valid,
  output word_t            redirect_pc,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int CW = $clog2(LOADUSE_BUBBLES + 1);

  hazard_state_t state_q, state_d;
  logic [CW-1:0] bub_q, bub_d;
  word_t         tgt_q, tgt_d;

  hazard_ctl_t   ctl_d, ctl;
  logic          rv_d;
  word_t         rpc_d;

  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    tgt_d   = tgt_q;
    ctl_d   = '0;
    rv_d    = 1'b0;
    rpc_d   = '0;

    // A busy memory stage freezes the whole pipe and this FSM with it.
    if (dbus_busy) begin
      ctl_d.stall_f = 1'b1;
      ctl_d.stall_d = 1'b1;
      ctl_d.stall_e = 1'b1;
      ctl_d.stall_m = 1'b1;
    end else begin
      unique case (state_q)
        HZ_RUN: begin
          if (dec_hazard) begin
            ctl_d.stall_f = 1'b1;
            ctl_d.stall_d = 1'b1;
            ctl_d.flush_e = 1'b1;
            if (LOADUSE_BUBBLES > 1) begin
              bub_d   = CW'(LOADUSE_BUBBLES - 1);
              state_d = HZ_BUBBLE;
            end
          end else if (dec_jump && !ibus_busy) begin
            rv_d          = 1'b1;
            rpc_d         = dec_target;
            ctl_d.flush_d = 1'b1;
          end else if (dec_jump) begin
            tgt_d         = dec_target;
            ctl_d.stall_f = 1'b1;
            ctl_d.flush_d = 1'b1;
            state_d       = HZ_REDIR_WAIT;
          end else if (ibus_busy) begin
            ctl_d.stall_f = 1'b1;
            ctl_d.flush_d = 1'b1;
          end
        end
        HZ_BUBBLE: begin
          ctl_d.stall_f = 1'b1;
          ctl_d.stall_d = 1'b1;
          ctl_d.flush_e = 1'b1;
          bub_d         = bub_q - CW'(1);
          if (bub_d == '0) state_d = HZ_RUN;
        end
        HZ_REDIR_WAIT: begin
          ctl_d.flush_d = 1'b1;
          if (ibus_busy) begin
            ctl_d.stall_f = 1'b1;
          end else begin
            rv_d    = 1'b1;
            rpc_d   = tgt_q;
            state_d = HZ_RUN;
          end
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HZ_RUN;
      bub_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      tgt_q   <= tgt_d;
    end
  end

  // Controls are Mealy, so reset must mask them directly rather than via state.
  assign ctl            = resetn ? ctl_d : '0;
  assign redirect_valid = resetn & rv_d;
  assign redirect_pc    = resetn ? rpc_d : '0;

  assign stall_f = ctl.stall_f;
  assign stall_d = ctl.stall_d;
  assign stall_e = ctl.stall_e;
  assign stall_m = ctl.stall_m;
  assign flush_d = ctl.flush_d;
  assign flush_e = ctl.flush_e;
  assign state_o = state_q;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .inc   (ctl.stall_d),
    .count (stall_cycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .inc   (redirect_valid),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a 3-bubble/32-bit-counter instance and a 1-bubble/2-bit-counter instance.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        dec_hazard = 1'b0, dec_jump = 1'b0, ibus_busy = 1'b0, dbus_busy = 1'b0;
  logic [63:0] dec_target = '0;

  logic        sf3, sd3, se3, sm3, fd3, fe3, rv3;
  logic [63:0] rpc3;
  logic [1:0]  st3;
  logic [31:0] sc3, rc3;

  logic        sf1, sd1, se1, sm1, fd1, fe1, rv1;
  logic [63:0] rpc1;
  logic [1:0]  st1;
  logic [1:0]  sc1, rc1;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOADUSE_BUBBLES(3), .CNT_W(32)) u3 (
    .clk(clk), .resetn(resetn), .dec_hazard(dec_hazard), .dec_jump(dec_jump),
    .dec_target(dec_target), .ibus_busy(ibus_busy), .dbus_busy(dbus_busy),
    .stall_f(sf3), .stall_d(sd3), .stall_e(se3), .stall_m(sm3),
    .flush_d(fd3), .flush_e(fe3), .redirect_valid(rv3), .redirect_pc(rpc3),
    .state_o(st3), .stall_cycles(sc3), .redirect_cnt(rc3)
  );

  hazard_ctrl #(.LOADUSE_BUBBLES(1), .CNT_W(2)) u1 (
    .clk(clk), .resetn(resetn), .dec_hazard(dec_hazard), .dec_jump(dec_jump),
    .dec_target(dec_target), .ibus_busy(ibus_busy), .dbus_busy(dbus_busy),
    .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
    .flush_d(fd1), .flush_e(fe1), .redirect_valid(rv1), .redirect_pc(rpc1),
    .state_o(st1), .stall_cycles(sc1), .redirect_cnt(rc1)
  );

  typedef struct {
    bit          dut;   // 0: u3, 1: u1
    logic        rstn, haz, jmp, ibus, dbus;
    logic [63:0] tgt;
    logic [5:0]  ctl;   // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    logic        rv;
    logic [63:0] rpc;
    logic [1:0]  st;
    logic [31:0] sc, rc;
  } vec_t;

  localparam logic [5:0] C0 = 6'b000000, CH = 6'b110001, CD = 6'b111100,
                         CF = 6'b000010, CI = 6'b100010;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(bit dut, logic rstn, logic haz, logic jmp, logic [63:0] tgt,
                              logic ibus, logic dbus, logic [5:0] ctl, logic rv,
                              logic [63:0] rpc, logic [1:0] st, logic [31:0] sc, logic [31:0] rc);
    vec_t v;
    v.dut = dut; v.rstn = rstn; v.haz = haz; v.jmp = jmp; v.tgt = tgt;
    v.ibus = ibus; v.dbus = dbus; v.ctl = ctl; v.rv = rv; v.rpc = rpc;
    v.st = st; v.sc = sc; v.rc = rc;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    resetn     = v.rstn;
    dec_hazard = v.haz;
    dec_jump   = v.jmp;
    dec_target = v.tgt;
    ibus_busy  = v.ibus;
    dbus_busy  = v.dbus;
    sb.push_back(v);
  endtask

  task automatic check(input int idx);
    vec_t        e;
    logic [5:0]  ctl;
    logic        rv;
    logic [63:0] rpc;
    logic [1:0]  st;
    logic [31:0] sc, rc;
    #2;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", idx, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    if (e.dut == 1'b0) begin
      ctl = {sf3, sd3, se3, sm3, fd3, fe3}; rv = rv3; rpc = rpc3; st = st3; sc = sc3; rc = rc3;
    end else begin
      ctl = {sf1, sd1, se1, sm1, fd1, fe1}; rv = rv1; rpc = rpc1; st = st1;
      sc = {30'd0, sc1}; rc = {30'd0, rc1};
    end
    cmp(e.dut ? "u1_ctl" : "u3_ctl", idx, {58'd0, ctl}, {58'd0, e.ctl});
    cmp(e.dut ? "u1_redirect_valid" : "u3_redirect_valid", idx, {63'd0, rv}, {63'd0, e.rv});
    cmp(e.dut ? "u1_redirect_pc" : "u3_redirect_pc", idx, rpc, e.rpc);
    cmp(e.dut ? "u1_state" : "u3_state", idx, {62'd0, st}, {62'd0, e.st});
    cmp(e.dut ? "u1_stall_cycles" : "u3_stall_cycles", idx, {32'd0, sc}, {32'd0, e.sc});
    cmp(e.dut ? "u1_redirect_cnt" : "u3_redirect_cnt", idx, {32'd0, rc}, {32'd0, e.rc});
  endtask

  initial begin
    // Main table against the 3-bubble instance: fields are
    // dut rstn haz jmp tgt ibus dbus | ctl rv rpc state stall_cycles redirect_cnt
    tbl.push_back(mk(0,0,1,1,64'h1234,1,1, C0,0,64'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,0,0));
    tbl.push_back(mk(0,1,1,0,64'h0,0,0, CH,0,64'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, CH,0,64'h0,1,1,0));
    tbl.push_back(mk(0,1,1,1,64'h55,0,0, CH,0,64'h0,1,2,0));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,3,0));
    tbl.push_back(mk(0,1,0,1,64'h8000_0040,0,0, CF,1,64'h8000_0040,0,3,0));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,3,1));
    tbl.push_back(mk(0,1,0,1,64'h8000_0100,1,0, CI,0,64'h0,0,3,1));
    tbl.push_back(mk(0,1,0,1,64'hdead,1,0, CI,0,64'h0,2,3,1));
    tbl.push_back(mk(0,1,1,0,64'h0,1,0, CI,0,64'h0,2,3,1));
    tbl.push_back(mk(0,1,0,0,64'h0,1,0, CI,0,64'h0,2,3,1));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, CF,1,64'h8000_0100,2,3,1));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,3,2));
    tbl.push_back(mk(0,1,0,1,64'h8000_0200,0,1, CD,0,64'h0,0,3,2));
    tbl.push_back(mk(0,1,0,1,64'h8000_0200,0,1, CD,0,64'h0,0,4,2));
    tbl.push_back(mk(0,1,0,1,64'h8000_0200,0,0, CF,1,64'h8000_0200,0,5,2));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,5,3));
    tbl.push_back(mk(0,1,1,0,64'h0,0,0, CH,0,64'h0,0,5,3));
    tbl.push_back(mk(0,1,0,0,64'h0,0,1, CD,0,64'h0,1,6,3));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, CH,0,64'h0,1,7,3));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, CH,0,64'h0,1,8,3));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,9,3));
    tbl.push_back(mk(0,1,0,1,64'h8000_0300,1,0, CI,0,64'h0,0,9,3));
    tbl.push_back(mk(0,1,0,0,64'h0,0,1, CD,0,64'h0,2,9,3));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, CF,1,64'h8000_0300,2,10,3));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,10,4));
    tbl.push_back(mk(0,1,0,0,64'h0,1,0, CI,0,64'h0,0,10,4));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,10,4));
    tbl.push_back(mk(0,1,0,1,64'h8000_0400,1,0, CI,0,64'h0,0,10,4));
    tbl.push_back(mk(0,0,0,0,64'h0,1,0, C0,0,64'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0,64'h0,0,0, C0,0,64'h0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      check(i);
    end

    // Single-bubble instance with 2-bit counters: one-cycle hazard, then counter wrap.
    drive(mk(1,0,0,0,64'h0,0,0, C0,0,64'h0,0,0,0));          check(100);
    drive(mk(1,1,0,0,64'h0,0,0, C0,0,64'h0,0,0,0));          check(101);
    drive(mk(1,1,1,1,64'h77,0,0, CH,0,64'h0,0,0,0));         check(102);
    drive(mk(1,1,0,0,64'h0,0,0, C0,0,64'h0,0,1,0));          check(103);
    for (int k = 0; k < 4; k++) begin
      drive(mk(1,1,1,0,64'h0,0,0, CH,0,64'h0,0,(32'd1 + k) % 4,0));
      check(104 + k);
    end
    drive(mk(1,1,0,0,64'h0,0,0, C0,0,64'h0,0,1,0));          check(108);
    for (int k = 0; k < 4; k++) begin
      drive(mk(1,1,0,1,64'h10 * (k + 1),0,0, CF,1,64'h10 * (k + 1),0,1,k));
      check(109 + k);
    end
    drive(mk(1,1,0,0,64'h0,0,0, C0,0,64'h0,0,1,0));          check(113);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
